dll_lock_monitor: RTL and testbench

Sits directly downstream of the clock-generation DLL and turns its raw `locked` status into a clean, debounced system reset for the 40 MHz fabric domain. It synchronises `locked` into the 40 MHz domain, requires a lock to stay stable for a programmable number of cycles, and extends reset by a hold window before release. It detects lock loss during operation, re-asserts reset, and keeps a saturating lock-loss counter and a sticky flag for slow-control readout.

---
 rtl/dll_lock_monitor_if.sv | 24 ++
 rtl/dll_lock_monitor.sv | 172 +++++++++++++++++
 tb/tb_dll_lock_monitor.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/dll_lock_monitor_if.sv
// Lock-monitor port bundle: raw DLL status and stats clear in, fabric reset and lock statistics out.
// The monitor takes the slave modport; whoever drives locked/clr_stat takes master.
interface dll_lock_monitor_if #(
    parameter int CNT_W = 8
);
    logic             locked;
    logic             clr_stat;
    logic             sys_rst_n;
    logic             clk_ok;
    logic             lost_pulse;
    logic             lost_flag;
    logic [CNT_W-1:0] unlock_cnt;
    logic             dll_rst_req;

    modport master (
        output locked, clr_stat,
        input  sys_rst_n, clk_ok, lost_pulse, lost_flag, unlock_cnt, dll_rst_req
    );

    modport slave (
        input  locked, clr_stat,
        output sys_rst_n, clk_ok, lost_pulse, lost_flag, unlock_cnt, dll_rst_req
    );
endinterface

// File: rtl/dll_lock_monitor.sv
// DLL lock monitor: synchronises locked, qualifies it (stable + hold window), drives sys_rst_n and lock-loss stats.
// Latency: release 2+STABLE+HOLD+1 cycles after first locked sample; loss seen 3 cycles after sample. No backpressure.
// Optional DLL_LOCK_TIMEOUT_EN builds a WAIT_LOCK timeout that pulses dll_rst_req.
module dll_lock_monitor #(
    parameter int STABLE_CYCLES  = 1024,
    parameter int HOLD_CYCLES    = 16,
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic               clkin,
    input  logic               rst_n,
    dll_lock_monitor_if.slave  bus
);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABILIZE = 3'd1,
        HOLD      = 3'd2,
        RUN       = 3'd3,
        LOST      = 3'd4
    } state_t;

    if (STABLE_CYCLES < 1 || STABLE_CYCLES > 65535 || HOLD_CYCLES < 1 ||
        HOLD_CYCLES > 255 || CNT_W < 1 || TIMEOUT_CYCLES < 1) begin : g_param_err
        $error("dll_lock_monitor: parameter out of range");
    end

    localparam logic [15:0]      STAB_MAX = 16'(STABLE_CYCLES);
    localparam logic [7:0]       HOLD_MAX = 8'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

    logic             locked_m, locked_s;
    state_t           state, state_nxt;
    logic [15:0]      stab_cnt, stab_nxt;
    logic [7:0]       hold_cnt, hold_nxt;
    logic             sys_rst_n_q, clk_ok_q, lost_pulse_q, lost_flag_q;
    logic [CNT_W-1:0] unlock_cnt_q;

    // locked is asynchronous to clkin
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            locked_m <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            locked_m <= bus.locked;
            locked_s <= locked_m;
        end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state    <= WAIT_LOCK;
            stab_cnt <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            stab_cnt <= stab_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stab_nxt  = stab_cnt;
        hold_nxt  = hold_cnt;
        case (state)
            WAIT_LOCK: begin
                stab_nxt = '0;
                hold_nxt = '0;
                if (locked_s) begin
                    state_nxt = STABILIZE;
                    stab_nxt  = 16'd1;
                end
            end
            STABILIZE: begin
                if (!locked_s) begin
                    state_nxt = WAIT_LOCK;
                    stab_nxt  = '0;
                end else if (stab_cnt == STAB_MAX) begin
                    state_nxt = HOLD;
                    stab_nxt  = '0;
                    hold_nxt  = 8'd1;
                end else begin
                    stab_nxt = stab_cnt + 16'd1;
                end
            end
            HOLD: begin
                if (!locked_s) begin
                    state_nxt = WAIT_LOCK;
                    hold_nxt  = '0;
                end else if (hold_cnt == HOLD_MAX) begin
                    state_nxt = RUN;
                    hold_nxt  = '0;
                end else begin
                    hold_nxt = hold_cnt + 8'd1;
                end
            end
            RUN: begin
                if (!locked_s) state_nxt = LOST;
            end
            LOST: begin
                state_nxt = WAIT_LOCK;
            end
            default: begin
                state_nxt = WAIT_LOCK;
                stab_nxt  = '0;
                hold_nxt  = '0;
            end
        endcase
    end

    // Outputs are a registered decode of the state register, giving the extra release/loss cycle.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            sys_rst_n_q  <= 1'b0;
            clk_ok_q     <= 1'b0;
            lost_pulse_q <= 1'b0;
            lost_flag_q  <= 1'b0;
            unlock_cnt_q <= '0;
        end else begin
            sys_rst_n_q  <= (state == RUN);
            clk_ok_q     <= (state == RUN);
            lost_pulse_q <= (state == LOST);
            if (state == LOST) begin
                // A clear landing on a loss still records that loss.
                lost_flag_q <= 1'b1;
                if (bus.clr_stat)
                    unlock_cnt_q <= {{(CNT_W-1){1'b0}}, 1'b1};
                else if (unlock_cnt_q != CNT_SAT)
                    unlock_cnt_q <= unlock_cnt_q + 1'b1;
            end else if (bus.clr_stat) begin
                lost_flag_q  <= 1'b0;
                unlock_cnt_q <= '0;
            end
        end
    end

`ifdef DLL_LOCK_TIMEOUT_EN
    localparam int              TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_END = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt;
    logic            dll_rst_req_q;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt        <= '0;
            dll_rst_req_q <= 1'b0;
        end else if (state != WAIT_LOCK) begin
            to_cnt        <= '0;
            dll_rst_req_q <= 1'b0;
        end else if (to_cnt == TO_END) begin
            to_cnt        <= '0;
            dll_rst_req_q <= 1'b1;
        end else begin
            to_cnt        <= to_cnt + 1'b1;
            dll_rst_req_q <= 1'b0;
        end
    end

    assign bus.dll_rst_req = dll_rst_req_q;
`else
    assign bus.dll_rst_req = 1'b0;
`endif

    assign bus.sys_rst_n  = sys_rst_n_q;
    assign bus.clk_ok     = clk_ok_q;
    assign bus.lost_pulse = lost_pulse_q;
    assign bus.lost_flag  = lost_flag_q;
    assign bus.unlock_cnt = unlock_cnt_q;

endmodule

// File: tb/tb_dll_lock_monitor.sv
// Bench for dll_lock_monitor: directed lock/loss/saturation/async-reset scenarios plus random lock glitches,
// checked every cycle against a run-length model of the lock qualification rules.
module tb_dll_lock_monitor;
    localparam int S  = 1024;
    localparam int H  = 16;
    localparam int CW = 2;
    localparam int T  = 100;
    localparam int MAXC = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    dll_lock_monitor_if #(.CNT_W(CW)) ifc ();

    dll_lock_monitor #(
        .STABLE_CYCLES (S),
        .HOLD_CYCLES   (H),
        .CNT_W         (CW),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clkin(clk),
        .rst_n(rst_n),
        .bus  (ifc)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a lock is released once locked_s has been seen high for S+H+1 consecutive edges;
    // a drop while released costs one dead cycle before counting can restart.
    int m_s1, m_s2, m_q, m_run, m_lost, m_tc;
    int e_srst, e_pulse, e_flag, e_cnt, e_req;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = 0; m_s2 = 0; m_q = 0; m_run = 0; m_lost = 0; m_tc = 0;
            e_srst = 0; e_pulse = 0; e_flag = 0; e_cnt = 0; e_req = 0;
        end else begin
            automatic int waiting = (!m_run && !m_lost && m_q == 0) ? 1 : 0;
            e_srst  = m_run;
            e_pulse = m_lost;
            if (m_lost != 0) begin
                if (ifc.clr_stat) e_cnt = 0;
                if (e_cnt < MAXC) e_cnt++;
                e_flag = 1;
            end else if (ifc.clr_stat) begin
                e_cnt = 0;
                e_flag = 0;
            end
            e_req = 0;
            if (waiting != 0) begin
                m_tc++;
                if (m_tc == T) begin
                    e_req = 1;
                    m_tc = 0;
                end
            end else begin
                m_tc = 0;
            end
            if (m_run != 0) begin
                if (m_s2 == 0) begin
                    m_run = 0; m_lost = 1; m_q = 0;
                end
            end else if (m_lost != 0) begin
                m_lost = 0;
            end else if (m_s2 != 0) begin
                m_q++;
                if (m_q == S + H + 1) m_run = 1;
            end else begin
                m_q = 0;
            end
            m_s2 = m_s1;
            m_s1 = ifc.locked ? 1 : 0;
        end
    end

    always @(negedge clk) begin
        check("sys_rst_n",  32'(ifc.sys_rst_n),  32'(e_srst));
        check("clk_ok",     32'(ifc.clk_ok),     32'(e_srst));
        check("lost_pulse", 32'(ifc.lost_pulse), 32'(e_pulse));
        check("lost_flag",  32'(ifc.lost_flag),  32'(e_flag));
        check("unlock_cnt", 32'(ifc.unlock_cnt), 32'(e_cnt));
`ifdef DLL_LOCK_TIMEOUT_EN
        check("dll_rst_req", 32'(ifc.dll_rst_req), 32'(e_req));
`else
        check("dll_rst_req", 32'(ifc.dll_rst_req), 32'd0);
`endif
    end

    // Call at a negedge right after raising locked; counts edges after the first sampling edge.
    task automatic wait_release(input string nm);
        int k = 0;
        @(posedge clk);
        while (k < 3000) begin
            @(posedge clk);
            k++;
            #1;
            if (ifc.sys_rst_n) break;
        end
        check(nm, k, 1043);
        check({nm, "_clk_ok"}, 32'(ifc.clk_ok), 32'd1);
        @(negedge clk);
    endtask

    // Call at a negedge while released; drops locked and checks the loss shows up at edge n+3.
    task automatic lose(input logic with_clr, input int exp_cnt);
        ifc.locked = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1 check("loss_n2_still_up", 32'(ifc.sys_rst_n), 32'd1);
        @(negedge clk);
        ifc.clr_stat = with_clr;
        @(posedge clk);
        #1;
        check("loss_pulse",     32'(ifc.lost_pulse), 32'd1);
        check("loss_sys_rst_n", 32'(ifc.sys_rst_n),  32'd0);
        check("loss_clk_ok",    32'(ifc.clk_ok),     32'd0);
        check("loss_flag",      32'(ifc.lost_flag),  32'd1);
        check("loss_cnt",       32'(ifc.unlock_cnt), 32'(exp_cnt));
        @(negedge clk);
        ifc.clr_stat = 1'b0;
        @(posedge clk);
        #1 check("loss_pulse_one_cycle", 32'(ifc.lost_pulse), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        ifc.locked   = 1'b0;
        ifc.clr_stat = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_sys_rst_n", 32'(ifc.sys_rst_n),  32'd0);
        check("reset_cnt",       32'(ifc.unlock_cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        ifc.locked = 1'b1;
        wait_release("powerup_latency");
        check("powerup_cnt", 32'(ifc.unlock_cnt), 32'd0);

        lose(1'b0, 1);
        ifc.locked = 1'b1;
        wait_release("relock_latency");

        // Glitch at cycle ~500 of STABILIZE restarts qualification.
        lose(1'b0, 2);
        ifc.locked = 1'b1;
        repeat (502) @(negedge clk);
        ifc.locked = 1'b0;
        repeat (3) @(negedge clk);
        ifc.locked = 1'b1;
        wait_release("unstable_latency");

        for (int i = 3; i <= 5; i++) begin
            lose(1'b0, (i > MAXC) ? MAXC : i);
            ifc.locked = 1'b1;
            wait_release("sat_relock");
        end
        check("saturated_cnt", 32'(ifc.unlock_cnt), 32'd3);
        lose(1'b1, 1);
        check("clr_on_loss_flag", 32'(ifc.lost_flag), 32'd1);

        for (int i = 0; i < 20; i++) begin
            automatic int hi = $urandom_range(1200, 0);
            automatic int lo = $urandom_range(4, 1);
            ifc.locked = 1'b1;
            for (int c = 0; c < hi; c++) begin
                ifc.clr_stat = ($urandom_range(49, 0) == 0);
                @(negedge clk);
            end
            ifc.clr_stat = 1'b0;
            ifc.locked = 1'b0;
            repeat (lo) @(negedge clk);
        end

        ifc.locked = 1'b1;
        repeat (8) @(negedge clk);
        ifc.locked = 1'b0;
        repeat (6) @(negedge clk);
        ifc.locked = 1'b1;
        wait_release("pre_async_latency");
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_sys_rst_n",  32'(ifc.sys_rst_n),   32'd0);
        check("async_clk_ok",     32'(ifc.clk_ok),      32'd0);
        check("async_lost_pulse", 32'(ifc.lost_pulse),  32'd0);
        check("async_lost_flag",  32'(ifc.lost_flag),   32'd0);
        check("async_unlock_cnt", 32'(ifc.unlock_cnt),  32'd0);
        check("async_dll_req",    32'(ifc.dll_rst_req), 32'd0);
        @(negedge clk);
        ifc.locked = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

`ifdef DLL_LOCK_TIMEOUT_EN
        begin
            int k = 0;
            while (k < 300 && !ifc.dll_rst_req) begin
                @(negedge clk);
                k++;
            end
            k = 0;
            @(negedge clk);
            k++;
            while (k < 300 && !ifc.dll_rst_req) begin
                @(negedge clk);
                k++;
            end
            check("timeout_period", k, T);
        end
`endif
        repeat (350) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
